// File: rtl/spi_pkg.sv
// Shared types and command encodings for the SPI slave front end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial MISO driver: loads a byte on i_load, emits it MSB first
// starting the following cycle, then drives 0 and raises o_done.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_miso,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_miso;
  logic              r_busy;
  logic              r_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_load) begin
      // MSB goes straight to the pin; the rest queue up behind it.
      r_shift <= {i_data[DATA_W-2:0], 1'b0};
      r_miso  <= i_data[DATA_W-1];
      r_cnt   <= CNT_W'(1);
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt == CNT_W'(DATA_W)) begin
        r_miso <= 1'b0;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_miso  <= r_shift[DATA_W-1];
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_miso = r_miso;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI frames into RAM words and serialises
// RAM read data onto MISO. Optional command check: SPI_SLV_CMD_CHECK_EN.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RX_W   = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [RX_W-1:0]   rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              cmd_err
);

  localparam int CNT_W = $clog2(RX_W);

  state_e          r_state, w_state_next;
  logic [RX_W-2:0] r_shift;
  logic [RX_W-1:0] r_rx_data, w_word;
  logic [CNT_W-1:0] r_bit_cnt;
  logic            r_word_done, r_rd_addr_flag, r_rd_wait, r_rx_valid;
  logic            w_in_frame, w_shift_en, w_complete, w_cmd_ok;
  logic            w_ser_load, w_ser_busy, w_ser_done, w_ser_miso;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_in_frame   = 1'b0;
    case (r_state)
      IDLE:    if (!SS_n) w_state_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                w_state_next = IDLE;
        else if (!MOSI)          w_state_next = WRITE;
        else if (r_rd_addr_flag) w_state_next = READ_DATA;
        else                     w_state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        w_in_frame = 1'b1;
        if (SS_n) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    w_shift_en = w_in_frame && !SS_n && !r_word_done;
    w_complete = w_shift_en && (r_bit_cnt == CNT_W'(RX_W - 1));
    w_word     = {r_shift, MOSI};
    // Only a successfully received READ_DATA word opens the tx window.
    w_ser_load = (r_state == READ_DATA) && !SS_n && r_rd_wait && tx_valid
                 && !w_ser_busy && !w_ser_done;
  end

`ifdef SPI_SLV_CMD_CHECK_EN
  logic r_cmd_err;

  always_comb begin
    w_cmd_ok = 1'b0;
    case (r_state)
      WRITE:     w_cmd_ok = (w_word[RX_W-1:RX_W-2] == CMD_WR_ADDR) ||
                            (w_word[RX_W-1:RX_W-2] == CMD_WR_DATA);
      READ_ADD:  w_cmd_ok = (w_word[RX_W-1:RX_W-2] == CMD_RD_ADDR);
      READ_DATA: w_cmd_ok = (w_word[RX_W-1:RX_W-2] == CMD_RD_DATA);
      default:   w_cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_cmd_err <= 1'b0;
    else     r_cmd_err <= w_complete && !w_cmd_ok;
  end

  assign cmd_err = r_cmd_err;
`else
  assign w_cmd_ok = 1'b1;
  assign cmd_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_word_done    <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_flag <= 1'b0;
      r_rd_wait      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_shift_en) begin
        r_shift <= w_word[RX_W-2:0];
        if (r_bit_cnt == CNT_W'(RX_W - 1)) r_word_done <= 1'b1;
        else                               r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
      end
      if (w_complete && w_cmd_ok) begin
        r_rx_data  <= w_word;
        r_rx_valid <= 1'b1;
        if (r_state == READ_ADD) r_rd_addr_flag <= 1'b1;
        if (r_state == READ_DATA) begin
          r_rd_addr_flag <= 1'b0;
          r_rd_wait      <= 1'b1;
        end
      end
      // Per-frame bookkeeping restarts whenever no frame body is active.
      if (r_state == IDLE || r_state == CHK_CMD) begin
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
        r_rd_wait   <= 1'b0;
      end
    end
  end

  spi_tx_serializer #(.DATA_W(DATA_W)) u_tx_ser (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (SS_n),
    .i_load (w_ser_load),
    .i_data (tx_data),
    .o_miso (w_ser_miso),
    .o_busy (w_ser_busy),
    .o_done (w_ser_done)
  );

  assign MISO     = w_ser_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl with a frame-level reference model.
module tb_spi_slave_ctrl;

  localparam int DATA_W = 8;
  localparam int RX_W   = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst, SS_n, MOSI, MISO, rx_valid, tx_valid, cmd_err;
  logic [RX_W-1:0]   rx_data;
  logic [DATA_W-1:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: read-address flag and last word delivered on rx_data.
  bit              m_flag;
  logic [RX_W-1:0] m_last;

  // Observations gathered while a frame runs.
  int              o_k, o_nvalid, o_first, o_nerr;
  logic [RX_W-1:0] o_data;
  bit              o_miso;

  typedef struct {
    bit              valid;
    bit              err;
    bit              rd_wait;
    bit              flag_next;
    logic [RX_W-1:0] data;
  } exp_t;

  spi_slave_ctrl #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Frame outcome from the frame type, the flag and the command bits.
  function automatic exp_t model_frame(input bit sel, input logic [RX_W-1:0] w,
                                       input bit full, input bit flag);
    exp_t e;
    int   kind;
    bit   ok;
    e.valid = 0; e.err = 0; e.rd_wait = 0; e.flag_next = flag; e.data = w;
    if (!full) return e;
    kind = !sel ? 0 : (flag ? 2 : 1);
    ok = 1;
`ifdef SPI_SLV_CMD_CHECK_EN
    if (kind == 0)      ok = (w[RX_W-1] == 1'b0);
    else if (kind == 1) ok = (w[RX_W-1:RX_W-2] == 2'd2);
    else                ok = (w[RX_W-1:RX_W-2] == 2'd3);
`endif
    if (ok) begin
      e.valid = 1;
      if (kind == 1) e.flag_next = 1;
      if (kind == 2) begin e.flag_next = 0; e.rd_wait = 1; end
    end else begin
      e.err = 1;
    end
    return e;
  endfunction

  task automatic apply_model(input exp_t e);
    m_flag = e.flag_next;
    if (e.valid) m_last = e.data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_obs();
    tick();
    o_k++;
    if (rx_valid === 1'b1) begin
      o_nvalid++;
      if (o_first < 0) o_first = o_k;
      o_data = rx_data;
    end
    if (cmd_err === 1'b1) o_nerr++;
    if (MISO !== 1'b0) o_miso = 1;
  endtask

  // Select bit plus nbits of w (MSB first); a full word gets 3 trailing junk bits.
  task automatic run_frame(input bit sel, input logic [RX_W-1:0] w,
                           input int nbits, input bit spur);
    o_k = 0; o_nvalid = 0; o_first = -1; o_nerr = 0; o_miso = 0; o_data = '0;
    SS_n = 1'b0; MOSI = 1'($urandom);
    tick_obs();
    MOSI = sel;
    tick_obs();
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[RX_W-1-i]; tx_valid = spur; tx_data = DATA_W'($urandom);
      tick_obs();
    end
    tx_valid = 1'b0;
    if (nbits == RX_W) begin
      repeat (3) begin MOSI = 1'($urandom); tick_obs(); end
    end
  endtask

  task automatic end_frame(input int n);
    SS_n = 1'b1; MOSI = 1'b0;
    repeat (n) tick_obs();
  endtask

  task automatic serial_read(input logic [DATA_W-1:0] d, input int tv2_at,
                             output logic pre, output logic [DATA_W-1:0] cap,
                             output logic tail);
    pre = MISO;
    tx_data = d; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      cap[i] = MISO;
      if (i == tv2_at) begin tx_valid = 1'b1; tx_data = ~d; end
      tick();
      tx_valid = 1'b0;
    end
    tail = MISO;
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    m_flag = 0; m_last = '0;
    n_checks++; if (MISO !== 1'b0) begin n_errors++; $display("FAIL reset_miso: got %b exp 0", MISO); end
    n_checks++; if (rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rx_valid: got %b exp 0", rx_valid); end
    n_checks++; if (rx_data !== '0) begin n_errors++; $display("FAIL reset_rx_data: got %h exp 000", rx_data); end
    n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_err: got %b exp 0", cmd_err); end
    tick();
  endtask

  task automatic test_write_addr();
    run_frame(0, 10'h0A5, RX_W, 0);
    n_checks++; if (o_nvalid !== 1) begin n_errors++; $display("FAIL wr_pulses: got %0d exp 1", o_nvalid); end
    n_checks++; if (o_first !== 12) begin n_errors++; $display("FAIL wr_latency: got %0d exp 12", o_first); end
    n_checks++; if (o_data !== 10'h0A5) begin n_errors++; $display("FAIL wr_data: got %h exp 0a5", o_data); end
    n_checks++; if (o_miso !== 0) begin n_errors++; $display("FAIL wr_miso: got %b exp 0", o_miso); end
    end_frame(2);
    m_last = 10'h0A5;
  endtask

  task automatic test_read_sequence();
    logic pre, tail;
    logic [DATA_W-1:0] cap;
    run_frame(1, 10'h20F, RX_W, 0);
    n_checks++; if (o_nvalid !== 1 || o_data !== 10'h20F) begin n_errors++; $display("FAIL ra_word: got %0d/%h exp 1/20f", o_nvalid, o_data); end
    serial_read(8'hFF, -1, pre, cap, tail);
    n_checks++; if (cap !== 8'h00) begin n_errors++; $display("FAIL ra_tx_ignored: got %h exp 00", cap); end
    end_frame(2);
    m_flag = 1; m_last = 10'h20F;
    run_frame(1, 10'h300, RX_W, 0);
    n_checks++; if (o_nvalid !== 1 || o_data !== 10'h300 || o_first !== 12) begin n_errors++; $display("FAIL rd_word: got %0d/%h/%0d exp 1/300/12", o_nvalid, o_data, o_first); end
    serial_read(8'hC3, 4, pre, cap, tail);
    n_checks++; if (pre !== 1'b0) begin n_errors++; $display("FAIL rd_miso_pre: got %b exp 0", pre); end
    n_checks++; if (cap !== 8'hC3) begin n_errors++; $display("FAIL rd_miso_bits: got %h exp c3", cap); end
    n_checks++; if (tail !== 1'b0) begin n_errors++; $display("FAIL rd_miso_tail: got %b exp 0", tail); end
    end_frame(2);
    m_flag = 0; m_last = 10'h300;
    // Flag must be clear now, so this read frame is another READ_ADD.
    run_frame(1, 10'h2AA, RX_W, 0);
    serial_read(8'h5A, -1, pre, cap, tail);
    n_checks++; if (o_data !== 10'h2AA || cap !== 8'h00) begin n_errors++; $display("FAIL rd_flag_clear: got %h/%h exp 2aa/00", o_data, cap); end
    end_frame(2);
    m_flag = 1; m_last = 10'h2AA;
  endtask

  task automatic test_abort();
    run_frame(0, 10'h0F0, 5, 0);
    end_frame(1);
    n_checks++; if (o_nvalid !== 0) begin n_errors++; $display("FAIL abort_pulses: got %0d exp 0", o_nvalid); end
    n_checks++; if (rx_data !== m_last) begin n_errors++; $display("FAIL abort_rx_data: got %h exp %h", rx_data, m_last); end
    run_frame(0, 10'h17E, RX_W, 0);
    n_checks++; if (o_nvalid !== 1 || o_data !== 10'h17E || o_first !== 12) begin n_errors++; $display("FAIL abort_next: got %0d/%h/%0d exp 1/17e/12", o_nvalid, o_data, o_first); end
    end_frame(2);
    m_last = 10'h17E;
  endtask

  task automatic test_spurious();
    logic pre, tail;
    logic [DATA_W-1:0] cap;
    bit bad;
    bad = 0;
    SS_n = 1'b1; tx_data = 8'hAA; tx_valid = 1'b1;
    repeat (3) begin tick(); if (MISO !== 1'b0) bad = 1; end
    tx_valid = 1'b0;
    n_checks++; if (bad) begin n_errors++; $display("FAIL spur_idle_miso: got 1 exp 0"); end
    run_frame(0, 10'h055, RX_W, 1);
    n_checks++; if (o_miso !== 0) begin n_errors++; $display("FAIL spur_write_miso: got %b exp 0", o_miso); end
    n_checks++; if (o_nvalid !== 1 || o_data !== 10'h055) begin n_errors++; $display("FAIL spur_write_data: got %0d/%h exp 1/055", o_nvalid, o_data); end
    serial_read(8'hFF, -1, pre, cap, tail);
    n_checks++; if (cap !== 8'h00) begin n_errors++; $display("FAIL spur_write_hold: got %h exp 00", cap); end
    end_frame(2);
    m_last = 10'h055;
  endtask

  task automatic test_reset_mid();
    logic pre, tail;
    logic [DATA_W-1:0] cap;
    exp_t e;
    if (!m_flag) begin
      run_frame(1, 10'h211, RX_W, 0);
      end_frame(2);
      m_flag = 1;
    end
    run_frame(1, 10'h3C5, RX_W, 0);
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (MISO !== 1'b1) begin n_errors++; $display("FAIL rstmid_bit4: got %b exp 1", MISO); end
    rst = 1'b1; SS_n = 1'b1;
    tick();
    n_checks++; if (MISO !== 1'b0 || rx_data !== '0) begin n_errors++; $display("FAIL rstmid_clear: got %b/%h exp 0/000", MISO, rx_data); end
    rst = 1'b0;
    m_flag = 0; m_last = '0;
    tick();
    // Set the flag, then reset: the next read frame must be READ_ADD again.
    run_frame(1, 10'h281, RX_W, 0);
    end_frame(2);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    m_flag = 0; m_last = '0;
    e = model_frame(1, 10'h3C3, 1, m_flag);
    run_frame(1, 10'h3C3, RX_W, 0);
    n_checks++; if (o_nvalid !== int'(e.valid) || o_nerr !== int'(e.err)) begin n_errors++; $display("FAIL rstflag_frame: got %0d/%0d exp %0d/%0d", o_nvalid, o_nerr, e.valid, e.err); end
    serial_read(8'h81, -1, pre, cap, tail);
    n_checks++; if (cap !== 8'h00) begin n_errors++; $display("FAIL rstflag_no_tx: got %h exp 00", cap); end
    apply_model(e);
    end_frame(2);
  endtask

  task automatic test_cmd_check();
    exp_t e;
    e = model_frame(0, 10'h301, 1, m_flag);
    run_frame(0, 10'h301, RX_W, 0);
    n_checks++; if (o_nvalid !== int'(e.valid)) begin n_errors++; $display("FAIL cmd_valid: got %0d exp %0d", o_nvalid, e.valid); end
    n_checks++; if (o_nerr !== int'(e.err)) begin n_errors++; $display("FAIL cmd_err: got %0d exp %0d", o_nerr, e.err); end
    apply_model(e);
    end_frame(2);
    n_checks++; if (rx_data !== m_last) begin n_errors++; $display("FAIL cmd_rx_data: got %h exp %h", rx_data, m_last); end
  endtask

  task automatic test_random();
    logic pre, tail;
    logic [DATA_W-1:0] cap, d, want;
    logic [RX_W-1:0] w;
    exp_t e;
    bit sel, full, spur;
    int nbits;
    for (int it = 0; it < 40; it++) begin
      sel = 1'($urandom);
      w = RX_W'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (!sel) w[RX_W-1] = 1'b0;
        else      w[RX_W-1:RX_W-2] = m_flag ? 2'd3 : 2'd2;
      end
      full  = ($urandom_range(0, 4) != 0);
      nbits = full ? RX_W : $urandom_range(0, RX_W - 1);
      spur  = 1'($urandom);
      e = model_frame(sel, w, full, m_flag);
      run_frame(sel, w, nbits, spur);
      n_checks++; if (o_nvalid !== int'(e.valid)) begin n_errors++; $display("FAIL rnd%0d_valid: got %0d exp %0d", it, o_nvalid, e.valid); end
      n_checks++; if (o_nerr !== int'(e.err)) begin n_errors++; $display("FAIL rnd%0d_err: got %0d exp %0d", it, o_nerr, e.err); end
      if (e.valid) begin
        n_checks++; if (o_data !== w || o_first !== 12) begin n_errors++; $display("FAIL rnd%0d_data: got %h@%0d exp %h@12", it, o_data, o_first, w); end
      end
      n_checks++; if (o_miso !== 0) begin n_errors++; $display("FAIL rnd%0d_frame_miso: got %b exp 0", it, o_miso); end
      if (full) begin
        d = DATA_W'($urandom);
        want = e.rd_wait ? d : '0;
        serial_read(d, -1, pre, cap, tail);
        n_checks++; if (cap !== want || tail !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_miso: got %h/%b exp %h/0", it, cap, tail, want); end
      end
      apply_model(e);
      end_frame($urandom_range(1, 2));
      n_checks++; if (rx_data !== m_last) begin n_errors++; $display("FAIL rnd%0d_rx_data: got %h exp %h", it, rx_data, m_last); end
    end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_sequence();
    test_abort();
    test_spurious();
    test_reset_mid();
    test_cmd_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
